ram_sp_clr: RTL and testbench

//  Parametrised single-port synchronous RAM. Next generation of the 4x16 RAM block.

---
 rtl/ram_sp_clr_pkg.sv | 12 +
 rtl/ram_clr_ctrl.sv | 56 +++++
 rtl/ram_sp_clr.sv | 76 +++++++
 tb/tb_ram_sp_clr.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_sp_clr_pkg.sv
// ram_sp_clr shared definitions.
// Clear-engine state encodings and depth helper.
package ram_sp_clr_pkg;

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_IDLE  = 1'b1;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/ram_clr_ctrl.sv
// Clear engine for ram_sp_clr.
// Sweeps clr_ptr over every word after reset or on request.
module ram_clr_ctrl
  import ram_sp_clr_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_ptr
);

  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  logic              state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_CLEAR: begin
        if (clr) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == LAST) state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy    = (state_q == ST_CLEAR);
  assign clr_we  = busy;
  assign clr_ptr = ptr_q;

endmodule

// File: rtl/ram_sp_clr.sv
// Single-port RAM with registered read and clear engine.
// Host access is gated while the sweep runs.
module ram_sp_clr
  import ram_sp_clr_pkg::*;
#(
  parameter int                DATA_W   = 4,
  parameter int                ADDR_W   = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              busy
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_ptr;

  ram_clr_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_ptr (clr_ptr)
  );

  logic [DATA_W-1:0] mem [DEPTH];

  logic              host_en, rd_acc, wr_acc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] q_q, q_d;
  logic              q_valid_q, q_valid_d;

  // clr wins over a same-cycle host access
  always_comb begin
    host_en   = !busy && !clr;
    rd_acc    = host_en && !rd;
    wr_acc    = host_en && !wr;
    mem_we    = clr_we || wr_acc;
    mem_wa    = clr_we ? clr_ptr : addr;
    mem_wd    = clr_we ? INIT_VAL : data_in;
    q_d       = rd_acc ? mem[addr] : q_q;
    q_valid_d = rd_acc;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;

endmodule

// File: tb/tb_ram_sp_clr.sv
// Directed bench for ram_sp_clr.
// Reference model plus read scoreboard queue.
module tb_ram_sp_clr;

  localparam logic [3:0] INIT = 4'hA;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clr, wr, rd;
  logic [3:0] addr, data_in;
  logic [3:0] q;
  logic       q_valid, busy;

  int checks = 0;
  int errors = 0;

  logic [3:0] mmem [16];
  logic [3:0] sbq [$];
  logic       m_busy;
  logic [3:0] m_ptr;
  logic [3:0] m_q;

  ram_sp_clr #(
    .DATA_W   (4),
    .ADDR_W   (4),
    .INIT_VAL (INIT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .wr      (wr),
    .rd      (rd),
    .addr    (addr),
    .data_in (data_in),
    .q       (q),
    .q_valid (q_valid),
    .busy    (busy)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    clr = 1'b0;
    wr = 1'b1;
    rd = 1'b1;
  endtask

  task automatic cyc();
    logic acc, racc, wacc;
    logic [3:0] e;
    acc  = !m_busy && !clr;
    racc = acc && !rd;
    wacc = acc && !wr;
    if (racc) sbq.push_back(mmem[addr]);
    if (wacc) mmem[addr] = data_in;
    @(posedge clk);
    if (m_busy) mmem[m_ptr] = INIT;
    if (clr) begin
      m_busy = 1'b1;
      m_ptr  = '0;
    end else if (m_busy) begin
      if (m_ptr == 4'hF) m_busy = 1'b0;
      m_ptr = m_ptr + 1'b1;
    end
    #10;
    chk("busy", busy, m_busy);
    if (racc) begin
      e = sbq.pop_front();
      chk("q_valid_hi", q_valid, 1);
      chk("q_read", q, e);
      m_q = e;
    end else begin
      chk("q_valid_lo", q_valid, 0);
      chk("q_hold", q, m_q);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b1;
    m_ptr  = '0;
    m_q    = '0;
    sbq.delete();
  endtask

  task automatic areset();
    #20 reset_n = 1'b0;
    #1;
    chk("rst_q", q, 0);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_busy", busy, 1);
    model_reset();
    #10 reset_n = 1'b1;
  endtask

  task automatic busy_len(input string tag,
                          input int exp);
    int n;
    n = 0;
    while (busy && n < 40) begin
      cyc();
      n++;
    end
    chk(tag, n, exp);
  endtask

  task automatic rd_word(input logic [3:0] a);
    idle();
    rd = 1'b0;
    addr = a;
    cyc();
  endtask

  task automatic wr_word(input logic [3:0] a,
                         input logic [3:0] d);
    idle();
    wr = 1'b0;
    addr = a;
    data_in = d;
    cyc();
  endtask

  initial begin
    idle();
    addr = '0;
    data_in = '0;
    for (int i = 0; i < 16; i++) mmem[i] = 'x;
    model_reset();
    reset_n = 1'b0;
    #20;
    chk("init_q", q, 0);
    chk("init_q_valid", q_valid, 0);
    chk("init_busy", busy, 1);
    #60 reset_n = 1'b1;

    // 1: power-up sweep then read all
    busy_len("sweep_len_reset", 16);
    for (int i = 0; i < 16; i++) rd_word(4'(i));

    // 2: write pattern, read back with idle gaps
    for (int i = 0; i < 16; i++) wr_word(4'(i), 4'(i));
    for (int i = 0; i < 16; i++) begin
      rd_word(4'(i));
      idle();
      cyc();
    end

    // 3: read-during-write
    wr_word(4'd5, 4'd3);
    idle();
    wr = 1'b0;
    rd = 1'b0;
    addr = 4'd5;
    data_in = 4'd9;
    cyc();
    rd_word(4'd5);

    // 4: clr beats a simultaneous write
    idle();
    clr = 1'b1;
    wr = 1'b0;
    addr = 4'd2;
    data_in = 4'd7;
    cyc();
    idle();
    busy_len("sweep_len_clr", 16);
    for (int i = 0; i < 16; i++) rd_word(4'(i));

    // 5: restart mid-sweep, host ignored
    rd_word(4'd4);
    idle();
    clr = 1'b1;
    cyc();
    idle();
    for (int i = 0; i < 8; i++) cyc();
    clr = 1'b1;
    cyc();
    idle();
    wr = 1'b0;
    rd = 1'b0;
    addr = 4'd3;
    data_in = 4'd5;
    busy_len("sweep_len_restart", 16);
    idle();
    rd_word(4'd3);

    // 6: async reset mid-sweep and mid-read
    idle();
    clr = 1'b1;
    cyc();
    idle();
    for (int i = 0; i < 5; i++) cyc();
    areset();
    busy_len("sweep_len_rst_mid", 16);
    wr_word(4'd7, 4'd1);
    rd_word(4'd7);
    chk("pre_rst_valid", q_valid, 1);
    areset();
    busy_len("sweep_len_rst_rd", 16);
    rd_word(4'd7);

    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
